microwave_ctrl: RTL

Top-level sequencing FSM for the microwave oven. It accepts keypad digits and start/stop/clear/door inputs, and drives the countdown timer's clrn/loadn/en/data controls. It watches the timer's zero flag and drives the magnetron enable and the end-of-cook beeper. It sits between the upstream debounced front-panel inputs and the existing timer block.

---
 rtl/microwave_pkg.sv | 15 +
 rtl/edge_detect.sv | 18 +
 rtl/microwave_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared state encoding and digit constants for the oven controller
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DIGIT_W     = 4;
  localparam int MAX_DECIMAL = 9;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - 1-bit rising-edge detector against a registered history bit
module edge_detect (
  input  logic clk,
  input  logic clrn,
  input  logic i_sig,
  output logic o_rise
);

  logic r_hist;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_hist <= 1'b0;
    else       r_hist <= i_sig;
  end

  assign o_rise = i_sig & ~r_hist;

endmodule

// File: rtl/microwave_ctrl.sv
// rtl/microwave_ctrl.sv - oven sequencing FSM driving the countdown timer, magnetron and beeper
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int MAX_DIGITS  = 3,
  parameter int BEEP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               door_closed,
  input  logic               timer_zero,
  output logic               timer_clrn,
  output logic               timer_loadn,
  output logic [DIGIT_W-1:0] timer_data,
  output logic               timer_en,
  output logic               mag_on,
  output logic               beep,
  output logic [2:0]         state_o
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic w_key_ev, w_start_ev, w_stop_ev, w_clear_ev, w_digit_ok;
  state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_digit_count, w_count_nxt;
  logic [7:0] r_beep_cnt, w_beep_cnt_nxt;
  logic r_timer_clrn, r_timer_loadn, r_timer_en, r_mag_on, r_beep;
  logic w_clrn_nxt, w_loadn_nxt;
  logic [DIGIT_W-1:0] r_timer_data, w_data_nxt;

  edge_detect u_ed_key   (.clk(clk), .clrn(clrn), .i_sig(key_valid), .o_rise(w_key_ev));
  edge_detect u_ed_start (.clk(clk), .clrn(clrn), .i_sig(start),     .o_rise(w_start_ev));
  edge_detect u_ed_stop  (.clk(clk), .clrn(clrn), .i_sig(stop),      .o_rise(w_stop_ev));
  edge_detect u_ed_clear (.clk(clk), .clrn(clrn), .i_sig(clear),     .o_rise(w_clear_ev));

  assign w_digit_ok = w_key_ev && (key_digit <= DIGIT_W'(MAX_DECIMAL)) &&
                      (r_digit_count < CNT_W'(MAX_DIGITS)) &&
                      (r_state == IDLE || r_state == SET);

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_digit_count;
    w_beep_cnt_nxt = r_beep_cnt;
    w_clrn_nxt     = 1'b1;
    w_loadn_nxt    = 1'b1;
    w_data_nxt     = r_timer_data;
    // Clear outranks every other event; a clear with nothing entered is a no-op.
    if (w_clear_ev && !(r_state == IDLE && r_digit_count == '0)) begin
      w_state_nxt    = IDLE;
      w_count_nxt    = '0;
      w_beep_cnt_nxt = '0;
      w_clrn_nxt     = 1'b0;
    end else begin
      case (r_state)
        IDLE:  if (w_digit_ok) w_state_nxt = SET;
        SET:   if (w_start_ev && door_closed && !timer_zero) w_state_nxt = COOK;
        COOK: begin
          if (!door_closed || w_stop_ev) begin
            w_state_nxt = PAUSE;
          end else if (timer_zero) begin
            w_state_nxt    = DONE;
            w_beep_cnt_nxt = 8'(BEEP_CYCLES - 1);
          end
        end
        PAUSE: if (w_start_ev && door_closed) w_state_nxt = COOK;
        DONE: begin
          if (r_beep_cnt == '0) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
          end else begin
            w_beep_cnt_nxt = r_beep_cnt - 8'd1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      // A start that actually launches the cook takes precedence over a same-cycle digit.
      if (w_digit_ok && w_state_nxt != COOK) begin
        w_loadn_nxt = 1'b0;
        w_data_nxt  = key_digit;
        w_count_nxt = r_digit_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state       <= IDLE;
      r_digit_count <= '0;
      r_beep_cnt    <= '0;
      r_timer_clrn  <= 1'b0;
      r_timer_loadn <= 1'b1;
      r_timer_data  <= '0;
      r_timer_en    <= 1'b0;
      r_mag_on      <= 1'b0;
      r_beep        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_digit_count <= w_count_nxt;
      r_beep_cnt    <= w_beep_cnt_nxt;
      r_timer_clrn  <= w_clrn_nxt;
      r_timer_loadn <= w_loadn_nxt;
      r_timer_data  <= w_data_nxt;
      r_timer_en    <= (w_state_nxt == COOK);
      r_mag_on      <= (w_state_nxt == COOK);
      r_beep        <= (w_state_nxt == DONE);
    end
  end

  assign timer_clrn  = r_timer_clrn;
  assign timer_loadn = r_timer_loadn;
  assign timer_data  = r_timer_data;
  assign timer_en    = r_timer_en;
  assign mag_on      = r_mag_on;
  assign beep        = r_beep;
  assign state_o     = r_state;

endmodule
